// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing a-b or |a-b| DIGIT bits per clock via a + ~b + 1.
// Valid/ready handshake on both sides; reports borrow (a<b) and zero flags.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SUB, SWAP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_rot, b_rot, res_shift;
  logic [CW-1:0]    count_reg;
  logic             carry_reg, mode_reg, borrow_reg;
  logic [DIGIT-1:0] x, y, sum;
  logic             c_out;
  logic             swap, stepping, last_step, accept, finish;

  assign swap      = (state_reg == SWAP);
  assign stepping  = (state_reg == SUB) || (state_reg == SWAP);
  assign last_step = (count_reg == CW'(N - 1));
  assign accept    = (state_reg == IDLE) && in_valid;
  assign finish    = stepping && last_step && (state_next == DONE);
  assign in_ready  = (state_reg == IDLE) && !rst;

  // The SWAP pass reuses the same adder with the operand roles exchanged.
  assign x = swap ? b_reg[DIGIT-1:0] : a_reg[DIGIT-1:0];
  assign y = swap ? a_reg[DIGIT-1:0] : b_reg[DIGIT-1:0];
  assign {c_out, sum} = {1'b0, x} + {1'b0, ~y} + {{DIGIT{1'b0}}, carry_reg};

  generate
    if (DIGIT == WIDTH) begin : g_full
      assign a_rot     = a_reg;
      assign b_rot     = b_reg;
      assign res_shift = sum;
    end else begin : g_digit
      logic [WIDTH-1:0] res_reg;

      assign a_rot     = {a_reg[DIGIT-1:0], a_reg[WIDTH-1:DIGIT]};
      assign b_rot     = {b_reg[DIGIT-1:0], b_reg[WIDTH-1:DIGIT]};
      assign res_shift = {sum, res_reg[WIDTH-1:DIGIT]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_reg <= '0;
        end else if (stepping) begin
          res_reg <= res_shift;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = SUB;
      SUB:  if (last_step) state_next = (mode_reg && !c_out) ? SWAP : DONE;
      SWAP: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= 1'b0;
      count_reg  <= '0;
      carry_reg  <= 1'b1;
      borrow_reg <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      mode_reg  <= in_mode;
      count_reg <= '0;
      carry_reg <= 1'b1;
    end else if (stepping) begin
      // Rotation restores both operands after N steps, ready for a SWAP pass.
      a_reg <= a_rot;
      b_reg <= b_rot;
      if (last_step) begin
        count_reg <= '0;
        carry_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + 1'b1;
        carry_reg <= c_out;
      end
      if (state_reg == SUB && last_step) begin
        borrow_reg <= ~c_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
    end else if (finish) begin
      out_valid  <= 1'b1;
      out_diff   <= res_shift;
      out_borrow <= swap ? borrow_reg : ~c_out;
      out_zero   <= (res_shift == '0);
    end else if (state_reg == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor: four instances (DIGIT 1,2,4,8) checked
// against an arithmetic reference for difference, borrow, zero and latency.
`timescale 1ns/1ps
module tb_serial_subtractor;
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid [NI];
  logic       in_ready [NI];
  logic       in_mode [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic       out_borrow [NI];
  logic       out_zero [NI];
  logic [7:0] in_a [NI];
  logic [7:0] in_b [NI];
  logic [7:0] out_diff [NI];

  int n_checks   = 0;
  int n_pass     = 0;
  int n_timeouts = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    serial_subtractor #(.WIDTH(8), .DIGIT(1 << gi)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .in_a       (in_a[gi]),
      .in_b       (in_b[gi]),
      .in_mode    (in_mode[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .out_diff   (out_diff[gi]),
      .out_borrow (out_borrow[gi]),
      .out_zero   (out_zero[gi])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int a, input int b, input int mode, input int k,
                                output int diff, output int borrow, output int lat);
    borrow = (a < b) ? 1 : 0;
    if (mode != 0) diff = (a >= b) ? (a - b) : (b - a);
    else           diff = (a - b + 256) % 256;
    lat = (8 >> k) * ((mode != 0 && a < b) ? 2 : 1);
  endfunction

  task automatic do_op(input int k, input int a, input int b, input int mode,
                       input int ediff, input int eborrow, input int elat,
                       input int in_gap, input int hold);
    int cyc;
    repeat (in_gap) tick();
    in_a[k]     = 8'(a);
    in_b[k]     = 8'(b);
    in_mode[k]  = 1'(mode);
    in_valid[k] = 1'b1;
    check_eq($sformatf("in_ready_idle k%0d", k), 32'(in_ready[k]), 32'd1);
    tick();
    in_valid[k] = 1'b0;
    cyc = 0;
    while (out_valid[k] !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
    if (cyc >= 64) n_timeouts++;
    check_eq($sformatf("latency k%0d", k), 32'(cyc), 32'(elat));
    check_eq($sformatf("diff k%0d", k), 32'(out_diff[k]), 32'(ediff));
    check_eq($sformatf("borrow k%0d", k), 32'(out_borrow[k]), 32'(eborrow));
    check_eq($sformatf("zero k%0d", k), 32'(out_zero[k]), (ediff == 0) ? 32'd1 : 32'd0);
    check_eq($sformatf("in_ready_done k%0d", k), 32'(in_ready[k]), 32'd0);
    repeat (hold) begin
      tick();
      check_eq($sformatf("hold_valid k%0d", k), 32'(out_valid[k]), 32'd1);
      check_eq($sformatf("hold_diff k%0d", k), 32'(out_diff[k]), 32'(ediff));
      check_eq($sformatf("hold_ready k%0d", k), 32'(in_ready[k]), 32'd0);
    end
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check_eq($sformatf("ack_valid k%0d", k), 32'(out_valid[k]), 32'd0);
    check_eq($sformatf("ack_ready k%0d", k), 32'(in_ready[k]), 32'd1);
    $display("op digit=%0d a=%0d b=%0d mode=%0d diff=%0d borrow=%0d zero=%0d latency=%0d",
             1 << k, a, b, mode, out_diff[k], out_borrow[k], out_zero[k], cyc);
  endtask

  typedef struct {
    int k; int a; int b; int mode; int ediff; int eborrow; int elat; int hold;
  } vec_t;

  vec_t dir_vecs [8] = '{
    '{0, 200,  55, 0, 145,  0,  8, 0},
    '{0,  55, 200, 0, 111,  1,  8, 0},
    '{0,  55, 200, 1, 145,  1, 16, 0},
    '{2,  90,  90, 1,   0,  0,  2, 0},
    '{2,   0,   1, 0, 255,  1,  2, 0},
    '{3,  10,  20, 1,  10,  1,  2, 1},
    '{1, 100, 100, 0,   0,  0,  4, 0},
    '{0, 200,  55, 0, 145,  0,  8, 5}
  };

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int a, b, mode, k, d, br, lat;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_mode[i]   = 1'b0;
      out_ready[i] = 1'b0;
      in_a[i]      = 8'd0;
      in_b[i]      = 8'd0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst_valid k%0d", i), 32'(out_valid[i]), 32'd0);
      check_eq($sformatf("rst_diff k%0d", i), 32'(out_diff[i]), 32'd0);
      check_eq($sformatf("rst_ready k%0d", i), 32'(in_ready[i]), 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(in_ready[0]), 32'd1);
    tick();

    foreach (dir_vecs[i])
      do_op(dir_vecs[i].k, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].mode,
            dir_vecs[i].ediff, dir_vecs[i].eborrow, dir_vecs[i].elat, 0, dir_vecs[i].hold);

    // Reset mid-operation: nothing may emerge and outputs must clear at once.
    in_a[0] = 8'd7; in_b[0] = 8'd9; in_mode[0] = 1'b1; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_valid[0]), 32'd0);
    check_eq("midrst_diff", 32'(out_diff[0]), 32'd0);
    check_eq("midrst_borrow", 32'(out_borrow[0]), 32'd0);
    check_eq("midrst_zero", 32'(out_zero[0]), 32'd0);
    check_eq("midrst_ready", 32'(in_ready[0]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_ready_after", 32'(in_ready[0]), 32'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid[0] === 1'b1) seen = 1;
    end
    check_eq("midrst_no_valid", 32'(seen), 32'd0);
    do_op(0, 55, 200, 1, 145, 1, 16, 0, 0);

    for (int i = 0; i < 1000 && n_timeouts < 4; i++) begin
      k    = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 255));
      b    = ($urandom_range(0, 15) == 0) ? a : int'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 1));
      model(a, b, mode, k, d, br, lat);
      do_op(k, a, b, mode, d, br, lat, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
